// File: rtl/div32_seq_pkg.sv
//==============================================================================
// Module      : div32_seq_pkg
// Description : Shared width default and FSM state encoding for div32_seq.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package div32_seq_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div32_seq_step.sv
//==============================================================================
// Module      : div32_seq_step
// Description : One combinational radix-2 restoring division step.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div32_seq_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r,
  input  logic            din,
  input  logic [XLEN-1:0] bmag,
  output logic [XLEN-1:0] r_next,
  output logic            qbit
);

  // Shifted remainder needs XLEN+1 bits so the carry out of r is not lost.
  logic [XLEN:0]   w_sh;
  logic [XLEN-1:0] w_diff;

  assign w_sh   = {r, din};
  assign qbit   = (w_sh >= {1'b0, bmag});
  // Difference is below bmag whenever it is selected, so XLEN bits suffice.
  assign w_diff = w_sh[XLEN-1:0] - bmag;
  assign r_next = qbit ? w_diff : w_sh[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/div32_seq.sv
//==============================================================================
// Module      : div32_seq
// Description : Iterative restoring divider for DIV/DIVU/REM/REMU, start/busy/done.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sgn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  localparam int              CW         = $clog2(XLEN);
  localparam logic [XLEN-1:0] c_min_neg  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_all_ones = '1;
  localparam logic [CW-1:0]   c_cnt_init = CW'(XLEN-1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sgn;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_bmag;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dq;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_done;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rout;

  logic [XLEN-1:0] w_amag;
  logic [XLEN-1:0] w_bmag;
  logic            w_ovf;
  logic [XLEN-1:0] w_step_r;
  logic            w_qbit;

  assign w_amag = (r_sgn && r_a[XLEN-1]) ? -r_a : r_a;
  assign w_bmag = (r_sgn && r_b[XLEN-1]) ? -r_b : r_b;
  assign w_ovf  = r_sgn && (r_a == c_min_neg) && (r_b == c_all_ones);

  // r_dq holds the dividend at its MSB end and collects quotient bits at the LSB.
  div32_seq_step #(.XLEN(XLEN)) u_step (
    .r      (r_rem),
    .din    (r_dq[XLEN-1]),
    .bmag   (r_bmag),
    .r_next (w_step_r),
    .qbit   (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sgn   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_bmag  <= '0;
      r_rem   <= '0;
      r_dq    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_rout  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sgn   <= sgn;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_bmag  <= w_bmag;
          r_cnt   <= c_cnt_init;
          r_neg_q <= r_sgn & (r_a[XLEN-1] ^ r_b[XLEN-1]);
          r_neg_r <= r_sgn & r_a[XLEN-1];
          r_rem   <= '0;
          r_dq    <= w_amag;
          r_state <= S_ITER;
          // Divide-by-zero and signed overflow bypass the loop with fixed results.
          if (r_b == '0) begin
            r_dq    <= c_all_ones;
            r_rem   <= r_a;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_state <= S_FIX;
          end else if (w_ovf) begin
            r_dq    <= c_min_neg;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_state <= S_FIX;
          end
        end
        S_ITER: begin
          r_rem <= w_step_r;
          r_dq  <= {r_dq[XLEN-2:0], w_qbit};
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          r_quo   <= r_neg_q ? -r_dq : r_dq;
          r_rout  <= r_neg_r ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign quo  = r_quo;
  assign rem  = r_rout;

endmodule

`default_nettype wire

// File: tb/tb_div32_seq.sv
//==============================================================================
// Module      : tb_div32_seq
// Description : Scoreboard bench for div32_seq with directed vectors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div32_seq;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  div32_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .quo   (quo),
    .rem   (rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      chk("done_width", {31'b0, prev_done}, 32'd0);
      chk("sb_nonempty", {31'b0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("quo", quo, e.q);
        chk("rem", rem, e.r);
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_done = done;
  end

  task automatic wait_done(output bit seen, output bit busy_drop);
    seen = 1'b0;
    busy_drop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_drop = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input vec_t v);
    bit seen, drop;
    @(negedge clk);
    sb.push_back('{q: v.q, r: v.r, cyc: cyc + v.lat});
    sgn = v.s; a = v.a; b = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; sgn = ~sgn;
    wait_done(seen, drop);
    chk("done_seen", {31'b0, seen}, 32'd1);
    chk("busy_held", {31'b0, drop}, 32'd0);
    @(negedge clk);
    chk("busy_after", {31'b0, busy}, 32'd0);
  endtask

  vec_t vecs[9] = '{
    '{1'b0, 32'd7,         32'd2,         32'd3,         32'd1,         35},
    '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  35},
    '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         35},
    '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         3},
    '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         3},
    '{1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9,  3},
    '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  35},
    '{1'b0, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  32'hF,         35},
    '{1'b0, 32'd3,         32'd9,         32'd0,         32'd3,         35}
  };

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen, drop;
    int d0;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quo", quo, 32'd0);
    chk("rst_rem", rem, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Starts during ITER and during DONE must be ignored.
    d0 = n_done;
    @(negedge clk);
    sb.push_back('{q: 32'd333, r: 32'd1, cyc: cyc + 35});
    sgn = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    a = 32'd50; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen, drop);
    chk("ign_done_seen", {31'b0, seen}, 32'd1);
    chk("ign_busy_held", {31'b0, drop}, 32'd0);
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_idle", {31'b0, busy}, 32'd0);
    repeat (45) @(negedge clk);
    chk("ign_done_count", 32'(n_done), 32'(d0 + 1));
    run_op('{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 35});

    // Reset mid-iteration aborts without a done pulse.
    d0 = n_done;
    @(negedge clk);
    sgn = 1'b0; a = 32'h12345678; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_quo", quo, 32'd0);
    chk("abort_rem", rem, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(n_done), 32'(d0));
    run_op('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 35});

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
